// File: rtl/vector_pack_feeder_if.sv
// Handshake bundle between the scalar element source, the feeder and the vector unit.
// The master side drives elements and coefficients and consumes vectors.
interface vector_pack_feeder_if #(
    parameter int bitwidth = 16,
    parameter int N        = 8
);
    logic [bitwidth-1:0]   s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;
    logic [bitwidth-1:0]   coef_b;
    logic [bitwidth-1:0]   coef_c;
    logic                  coef_load;
    logic [N*bitwidth-1:0] out_vec;
    logic [bitwidth-1:0]   out_b;
    logic [bitwidth-1:0]   out_c;
    logic [N-1:0]          out_mask;
    logic                  out_valid;
    logic                  out_last;
    logic                  out_ready;

    modport master (
        output s_data, s_valid, s_last, coef_b, coef_c, coef_load, out_ready,
        input  s_ready, out_vec, out_b, out_c, out_mask, out_valid, out_last
    );

    modport slave (
        input  s_data, s_valid, s_last, coef_b, coef_c, coef_load, out_ready,
        output s_ready, out_vec, out_b, out_c, out_mask, out_valid, out_last
    );
endinterface

// File: rtl/vector_pack_feeder.sv
// Packs a scalar element stream into N-lane vectors with per-vector b/c coefficients,
// zero padding of short tail vectors and a 1-entry valid/ready output register.
module vpf_lane #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] data,
    output logic [W-1:0] out_lane,
    output logic         out_m
);
    logic [W-1:0] lane_q;
    logic         m_q;

    // clear wins over write: a closing element bypasses the buffer straight to the output
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lane_q <= '0;
            m_q    <= 1'b0;
        end else if (wr) begin
            lane_q <= data;
            m_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_lane <= '0;
            out_m    <= 1'b0;
        end else if (ld) begin
            out_lane <= wr ? data : lane_q;
            out_m    <= wr | m_q;
        end
    end
endmodule

module vector_pack_feeder #(
    parameter int bitwidth = 16,
    parameter int N        = 8
) (
    input logic                  clk,
    input logic                  rst,
    vector_pack_feeder_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {FILL, PEND} state_t;

    state_t                           state, state_nxt;
    logic [CW-1:0]                    cnt;
    logic [bitwidth-1:0]              cur_b, cur_c, vec_b, vec_c, b_now, c_now;
    logic [bitwidth-1:0]              out_b_q, out_c_q;
    logic                             out_valid_q, out_last_q, pend_last;
    logic                             s_ready_c, acc, is_close, slot_free, ld_out, clr;
    logic [N-1:0][bitwidth-1:0]       lane_out;
    logic [N-1:0]                     mask_out;

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ld_out    = 1'b0;
        clr       = 1'b0;
        s_ready_c = (state == FILL);
        acc       = bus.s_valid && s_ready_c;
        is_close  = acc && ((cnt == CW'(N-1)) || bus.s_last);
        slot_free = !out_valid_q || bus.out_ready;
        case (state)
            FILL: begin
                if (is_close) begin
                    if (slot_free) begin
                        ld_out = 1'b1;
                        clr    = 1'b1;
                    end else begin
                        state_nxt = PEND;
                    end
                end
            end
            PEND: begin
                if (slot_free) begin
                    ld_out    = 1'b1;
                    clr       = 1'b1;
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // coefficients seen by the vector under assembly; a lane-0 accept snapshots them,
    // taking a same-cycle coef_load into account
    always_comb begin
        b_now = vec_b;
        c_now = vec_c;
        if (acc && (cnt == '0)) begin
            b_now = bus.coef_load ? bus.coef_b : cur_b;
            c_now = bus.coef_load ? bus.coef_c : cur_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            cur_b     <= '0;
            cur_c     <= '0;
            vec_b     <= '0;
            vec_c     <= '0;
            pend_last <= 1'b0;
        end else begin
            if (is_close)  cnt <= '0;
            else if (acc)  cnt <= cnt + CW'(1);
            if (bus.coef_load) begin
                cur_b <= bus.coef_b;
                cur_c <= bus.coef_c;
            end
            vec_b <= b_now;
            vec_c <= c_now;
            if (is_close) pend_last <= bus.s_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_b_q     <= '0;
            out_c_q     <= '0;
        end else if (ld_out) begin
            out_valid_q <= 1'b1;
            out_last_q  <= (state == FILL) ? bus.s_last : pend_last;
            out_b_q     <= b_now;
            out_c_q     <= c_now;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        vpf_lane #(.W(bitwidth)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .wr       (acc && (cnt == CW'(i))),
            .clr      (clr),
            .ld       (ld_out),
            .data     (bus.s_data),
            .out_lane (lane_out[i]),
            .out_m    (mask_out[i])
        );
    end

    assign bus.s_ready   = s_ready_c;
    assign bus.out_vec   = lane_out;
    assign bus.out_mask  = mask_out;
    assign bus.out_b     = out_b_q;
    assign bus.out_c     = out_c_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_vector_pack_feeder.sv
// Directed bench: expected vectors go into a scoreboard queue at stimulus time and a
// negedge monitor pops and compares each output handshake.
module tb_vector_pack_feeder;
    localparam int BW = 16;
    localparam int N  = 8;
    localparam int VW = N * BW;

    typedef struct {
        logic [VW-1:0] vec;
        logic [BW-1:0] b;
        logic [BW-1:0] c;
        logic [N-1:0]  mask;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    vector_pack_feeder_if #(.bitwidth(BW), .N(N)) vif ();

    vector_pack_feeder #(.bitwidth(BW), .N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int first, input int count, input logic [BW-1:0] b,
                                input logic [BW-1:0] c, input logic last);
        exp_t e;
        e.vec  = '0;
        e.mask = '0;
        for (int i = 0; i < count; i++) begin
            e.vec[i*BW +: BW] = BW'(first + i);
            e.mask[i]         = 1'b1;
        end
        e.b    = b;
        e.c    = c;
        e.last = last;
        return e;
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] got, input logic [VW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // offers one element until accepted; s_ready only changes at posedge so the negedge sample holds
    task automatic push(input logic [BW-1:0] d, input logic l, input logic cl,
                        input logic [BW-1:0] b, input logic [BW-1:0] c);
        bit ok;
        int n;
        vif.s_data    = d;
        vif.s_last    = l;
        vif.s_valid   = 1'b1;
        vif.coef_load = cl;
        vif.coef_b    = b;
        vif.coef_c    = c;
        ok = 1'b0;
        n  = 0;
        while (!ok) begin
            @(negedge clk);
            ok = vif.s_ready;
            @(posedge clk);
            #1;
            n++;
            if (!ok && n > 200) begin
                checks++;
                errors++;
                $display("FAIL push_timeout: element %h not accepted in %0d cycles", d, n);
                break;
            end
        end
        vif.s_valid   = 1'b0;
        vif.s_last    = 1'b0;
        vif.coef_load = 1'b0;
    endtask

    task automatic send_seq(input int first, input int count, input bit last_final);
        for (int i = 0; i < count; i++)
            push(BW'(first + i), last_final && (i == count - 1), 1'b0, '0, '0);
    endtask

    task automatic load_coef(input logic [BW-1:0] b, input logic [BW-1:0] c);
        vif.coef_b    = b;
        vif.coef_c    = c;
        vif.coef_load = 1'b1;
        cyc(1);
        vif.coef_load = 1'b0;
    endtask

    // monitor: compares each handshake against the scoreboard and checks hold stability
    initial begin
        exp_t           e;
        logic           held_prev;
        logic [VW-1:0]  h_vec;
        logic [BW-1:0]  h_b, h_c;
        logic [N-1:0]   h_mask;
        logic           h_last;
        held_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && held_prev && vif.out_valid) begin
                checks++;
                if (vif.out_vec !== h_vec || vif.out_b !== h_b || vif.out_c !== h_c ||
                    vif.out_mask !== h_mask || vif.out_last !== h_last) begin
                    errors++;
                    $display("FAIL hold_stable: got vec=%h b=%h c=%h mask=%h last=%b want vec=%h b=%h c=%h mask=%h last=%b",
                             vif.out_vec, vif.out_b, vif.out_c, vif.out_mask, vif.out_last,
                             h_vec, h_b, h_c, h_mask, h_last);
                end
            end
            if (!rst && vif.out_valid && vif.out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL extra_vector: got vec=%h mask=%h last=%b want none",
                             vif.out_vec, vif.out_mask, vif.out_last);
                end else begin
                    e = sb.pop_front();
                    if (vif.out_vec !== e.vec || vif.out_b !== e.b || vif.out_c !== e.c ||
                        vif.out_mask !== e.mask || vif.out_last !== e.last) begin
                        errors++;
                        $display("FAIL vector: got vec=%h b=%h c=%h mask=%h last=%b want vec=%h b=%h c=%h mask=%h last=%b",
                                 vif.out_vec, vif.out_b, vif.out_c, vif.out_mask, vif.out_last,
                                 e.vec, e.b, e.c, e.mask, e.last);
                    end
                end
            end
            held_prev = !rst && vif.out_valid && !vif.out_ready;
            h_vec  = vif.out_vec;
            h_b    = vif.out_b;
            h_c    = vif.out_c;
            h_mask = vif.out_mask;
            h_last = vif.out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vif.s_data    = '0;
        vif.s_valid   = 1'b0;
        vif.s_last    = 1'b0;
        vif.coef_b    = '0;
        vif.coef_c    = '0;
        vif.coef_load = 1'b0;
        vif.out_ready = 1'b0;
        rst = 1'b1;
        cyc(2);

        // reset state
        chk("rst_s_ready",   vif.s_ready,   1);
        chk("rst_out_valid", vif.out_valid, 0);
        chk("rst_out_vec",   vif.out_vec,   0);
        chk("rst_out_b",     vif.out_b,     0);
        chk("rst_out_c",     vif.out_c,     0);
        chk("rst_out_mask",  vif.out_mask,  0);
        chk("rst_out_last",  vif.out_last,  0);
        rst = 1'b0;
        cyc(1);

        // two full vectors back to back, first appears the cycle after element 8
        vif.out_ready = 1'b1;
        load_coef(16'h4000, 16'h3C00);
        sb.push_back(mk(1, 8, 16'h4000, 16'h3C00, 1'b0));
        sb.push_back(mk(9, 8, 16'h4000, 16'h3C00, 1'b1));
        send_seq(1, 8, 1'b0);
        chk("latency_v1", vif.out_valid, 1);
        send_seq(9, 8, 1'b1);
        chk("no_bubble_v2", vif.out_valid, 1);
        cyc(3);

        // lone last element, then a 3-element tail vector
        sb.push_back(mk(16'h55, 1, 16'h4000, 16'h3C00, 1'b1));
        push(16'h0055, 1'b1, 1'b0, '0, '0);
        cyc(3);
        sb.push_back(mk(16'h31, 3, 16'h4000, 16'h3C00, 1'b1));
        send_seq(16'h31, 3, 1'b1);
        cyc(3);

        // backpressure: vector 1 held, vector 2 pends, a single ready pulse moves it
        vif.out_ready = 1'b0;
        sb.push_back(mk(16'h101, 8, 16'h4000, 16'h3C00, 1'b0));
        sb.push_back(mk(16'h109, 8, 16'h4000, 16'h3C00, 1'b0));
        sb.push_back(mk(16'h111, 4, 16'h4000, 16'h3C00, 1'b1));
        send_seq(16'h101, 16, 1'b0);
        chk("pend_s_ready", vif.s_ready, 0);
        chk("pend_out_valid", vif.out_valid, 1);
        cyc(3);
        vif.out_ready = 1'b1;
        cyc(1);
        vif.out_ready = 1'b0;
        chk("s_ready_after_xfer", vif.s_ready, 1);
        chk("v2_valid_after_xfer", vif.out_valid, 1);
        send_seq(16'h111, 4, 1'b1);
        cyc(2);
        vif.out_ready = 1'b1;
        cyc(4);

        // coefficient timing: mid-vector load goes to the next vector; lane-0 load lands at once
        sb.push_back(mk(16'h201, 8, 16'h4000, 16'h3C00, 1'b0));
        sb.push_back(mk(16'h209, 8, 16'h4200, 16'h3C00, 1'b0));
        sb.push_back(mk(16'h211, 2, 16'h4400, 16'h3800, 1'b1));
        for (int i = 0; i < 8; i++)
            push(BW'(16'h201 + i), 1'b0, (i == 4), 16'h4200, 16'h3C00);
        send_seq(16'h209, 8, 1'b0);
        push(16'h0211, 1'b0, 1'b1, 16'h4400, 16'h3800);
        push(16'h0212, 1'b1, 1'b0, '0, '0);
        cyc(3);

        // reset while pending with a held output
        vif.out_ready = 1'b0;
        send_seq(16'h301, 16, 1'b0);
        chk("pre_rst_valid", vif.out_valid, 1);
        chk("pre_rst_s_ready", vif.s_ready, 0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("post_rst_valid",   vif.out_valid, 0);
        chk("post_rst_s_ready", vif.s_ready,   1);
        chk("post_rst_out_b",   vif.out_b,     0);
        chk("post_rst_out_c",   vif.out_c,     0);
        sb.delete();
        vif.out_ready = 1'b1;
        sb.push_back(mk(16'h401, 8, 16'h0000, 16'h0000, 1'b1));
        send_seq(16'h401, 8, 1'b1);
        cyc(5);

        chk("scoreboard_drained", VW'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vector_pack_feeder.md
Name: vector_pack_feeder

Overview:
- Feeder for the N-lane fused multiply-subtract vector datapath (out[i] = a[i]*b - c).
- Accepts a scalar element stream and packs N consecutive elements into one vector word. Attaches the scalar b/c coefficients, and presents vector, coefficients, valid and last to the vector unit.
- Zero-pads a short final vector and reports which lanes are real.
- Has a 1-entry output register with valid/ready, so an upstream stall or a downstream FIFO almost-full both throttle cleanly.

Parameters:
- bitwidth, 16, width of one element and of each coefficient (half-precision float).
- N, 8, lanes per vector; must be >= 2.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- s_data  input  bitwidth  scalar element
- s_valid  input  1  element valid
- s_last  input  1  element is last of packet
- s_ready  output  1  element accepted when s_valid & s_ready
- coef_b  input  bitwidth  multiplier coefficient
- coef_c  input  bitwidth  subtrahend coefficient
- coef_load  input  1  latch coef_b/coef_c into current-coefficient register
- out_vec  output  N*bitwidth  packed vector; lane i at [i*bitwidth +: bitwidth]
- out_b  output  bitwidth  coefficient b for this vector
- out_c  output  bitwidth  coefficient c for this vector
- out_mask  output  N  bit i = lane i holds a real element
- out_valid  output  1  vector valid
- out_last  output  1  vector closes a packet
- out_ready  input  1  downstream can take vector

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - s_ready=1, all other outputs 0.
  - Lane counter cnt=0, state FILL.
  - cur_b=cur_c=0, assembly buffer cleared.
- Coefficients:
  - coef_load writes cur_b/cur_c on the next edge.
  - Each vector snapshots cur_b/cur_c in the cycle its lane-0 element is accepted.
  - If coef_load coincides with the lane-0 accept, the new values are used.
  - Changes mid-vector affect only later vectors.
- Handoff condition:
  - slot_free = !out_valid | out_ready.
  - Output register updates only when slot_free.
  - out_valid drops after a handshake unless a new vector loads in the same cycle.
- FSM state FILL:
  - s_ready=1.
  - Accept writes s_data to lane cnt; mask bit cnt set.
  - Vector closes on accepting lane N-1 or an element with s_last=1.
  - Close with slot_free: the assembled vector, including the closing element, loads into the output register on the same edge. out_last=s_last. Lanes above the closing lane are 0x0000 with mask bits 0. cnt becomes 0 and the buffer/mask clear.
  - Close without slot_free: go to PEND; the buffer holds the complete vector.
- FSM state PEND:
  - s_ready=0.
  - When slot_free: load the buffer to the output register, cnt becomes 0, go to FILL.
  - s_ready returns to 1 the cycle after the transfer.
- Latency and throughput:
  - Closing element accepted at edge t gives out_valid high from t+1 when the slot is free.
  - Sustained throughput is one element per cycle with out_ready=1; no bubbles between vectors.
- s_last on lane N-1: a single full vector with out_last=1, mask all-ones; no empty extra vector.
- Lone s_last element: vector with lane 0 only, mask=...0001, out_last=1.
- out_vec/out_b/out_c/out_mask/out_last hold stable while out_valid=1 and out_ready=0.
- rst mid-packet or mid-PEND: partial vector discarded, out_valid=0 next cycle, coefficients cleared to 0.
- Width rule: cnt is ceil(log2 N) bits; it never exceeds N-1 (wrap-around to 0 only via vector close).

Test Plan:
- N=8, coef_load b=0x4000 c=0x3C00, stream 16 elements 1..16 with s_last on the 16th, out_ready=1 -> two vectors; each has b=0x4000, c=0x3C00, mask 0xFF. First has lanes 1..8, out_last=0, out_valid at the cycle after element 8. Second has lanes 9..16, out_last=1.
- Stream 3 elements with s_last on the 3rd -> one vector, lanes 0..2 data, lanes 3..7 = 0x0000, mask 0x07, out_last=1.
- Hold out_ready=0 while streaming 20 elements -> first vector held stable. Second vector fills, then s_ready=0 (PEND). Raise out_ready for 1 cycle -> vector 2 moves to output and s_ready=1 the next cycle; no element lost or duplicated.
- Pulse coef_load b=0x4200 during lane 4 of vector A, then start vector B -> A keeps the old b, B carries 0x4200. coef_load coinciding with B's lane-0 accept also lands in B.
- Assert rst while in PEND with out_valid=1 -> next cycle out_valid=0, s_ready=1, out_b=0. A fresh 8-element packet then produces exactly one correct vector.
- Single element with s_last -> mask 0x01, out_last=1, one vector only.
